// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: reset/bubble/halt encodings and
// the instruction-fetch FSM state type.
package mips_pkg;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter for the IF stage: holds the PC, selects between a redirect
// target, the sequential PC+4, or holding, and exposes PC+4 for IF/ID.
module pc_reg #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clka,
  input  logic            rst_n,
  input  logic            load_target,
  input  logic            advance,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus4
);

  assign pc_plus4 = pc + PC_W'(4);

  // Redirect wins over sequential advance; otherwise the PC is held.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (load_target) begin
      pc <= target;
    end else if (advance) begin
      pc <= pc_plus4;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// MIPS IF stage. Drives the instruction RAM address from the PC, captures the
// returned word into the IF/ID register one cycle later, and handles stall,
// branch/jump redirect with flush, debug single-step and HALT detection.
module instruction_fetch
  import mips_pkg::fetch_state_t, mips_pkg::RUN, mips_pkg::HALTED;
#(
  parameter int                 PC_W       = 32,
  parameter int                 ADDR_W     = 11,
  parameter int                 INSTR_W    = 32,
  parameter logic [PC_W-1:0]    RESET_PC   = PC_W'(mips_pkg::RESET_PC),
  parameter logic [INSTR_W-1:0] HALT_INSTR = INSTR_W'(mips_pkg::HALT_INSTR),
  parameter logic [INSTR_W-1:0] NOP_INSTR  = INSTR_W'(mips_pkg::NOP_INSTR)
) (
  input  logic               clka,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  o_addr,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic               i_stall,
  input  logic               i_branch_taken,
  input  logic [PC_W-1:0]    i_branch_target,
  input  logic               i_jump,
  input  logic [PC_W-1:0]    i_jump_target,
  input  logic               i_debug_mode,
  input  logic               i_step,
  output logic [INSTR_W-1:0] o_ifid_instr,
  output logic [PC_W-1:0]    o_ifid_pc4,
  output logic               o_ifid_valid,
  output logic [PC_W-1:0]    o_pc,
  output logic               o_halted,
  output logic [31:0]        o_fetch_count
);

  fetch_state_t    state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_plus4;
  logic [PC_W-1:0] redirect_target;
  logic            running;
  logic            redirect;
  logic            adv;
  logic            accept;
  logic            fetch_halt;
  logic            load_target;
  logic            advance_pc;

  // Branch comes from EX and is older than a jump from ID, so it wins.
  // A redirect bypasses stall and debug gating, but a halted core ignores it.
  assign running         = (state == RUN);
  assign redirect        = i_branch_taken | i_jump;
  assign redirect_target = i_branch_taken ? i_branch_target : i_jump_target;
  assign adv             = running & (~i_debug_mode | i_step);
  assign accept          = adv & ~redirect & ~i_stall;
  assign fetch_halt      = (i_instr == HALT_INSTR);
  assign load_target     = running & redirect;
  assign advance_pc      = accept & ~fetch_halt;

  pc_reg #(
    .PC_W    (PC_W),
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clka       (clka),
    .rst_n      (rst_n),
    .load_target(load_target),
    .advance    (advance_pc),
    .target     (redirect_target),
    .pc         (pc),
    .pc_plus4   (pc_plus4)
  );

  // IF/ID register, fetch counter and RUN/HALTED FSM; a fetched HALT word is
  // passed downstream once as valid, then bubbles follow until reset.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RUN;
      o_ifid_instr  <= NOP_INSTR;
      o_ifid_pc4    <= '0;
      o_ifid_valid  <= 1'b0;
      o_fetch_count <= '0;
    end else if (state == HALTED) begin
      o_ifid_instr  <= NOP_INSTR;
      o_ifid_pc4    <= '0;
      o_ifid_valid  <= 1'b0;
    end else if (redirect) begin
      o_ifid_instr  <= NOP_INSTR;
      o_ifid_pc4    <= '0;
      o_ifid_valid  <= 1'b0;
    end else if (accept) begin
      o_ifid_instr  <= i_instr;
      o_ifid_pc4    <= pc_plus4;
      o_ifid_valid  <= 1'b1;
      o_fetch_count <= o_fetch_count + 32'd1;
      if (fetch_halt) begin
        state <= HALTED;
      end
    end
  end

  assign o_addr   = pc[ADDR_W-1:0];
  assign o_pc     = pc;
  assign o_halted = (state == HALTED);

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: a behavioural low-latency RAM
// (samples on negedge) plus a per-cycle reference model of the fetch rules.
module tb_instruction_fetch;
  import mips_pkg::*;

  logic        clka = 1'b0;
  logic        rst_n;
  logic [10:0] o_addr;
  logic [31:0] i_instr;
  logic        i_stall;
  logic        i_branch_taken;
  logic [31:0] i_branch_target;
  logic        i_jump;
  logic [31:0] i_jump_target;
  logic        i_debug_mode;
  logic        i_step;
  logic [31:0] o_ifid_instr;
  logic [31:0] o_ifid_pc4;
  logic        o_ifid_valid;
  logic [31:0] o_pc;
  logic        o_halted;
  logic [31:0] o_fetch_count;

  logic [31:0] mem [0:511];
  logic [31:0] ram_dout;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc, m_instr, m_pc4, m_count;
  logic        m_valid, m_halted;
  logic        dbg = 1'b0;

  instruction_fetch dut (
    .clka           (clka),
    .rst_n          (rst_n),
    .o_addr         (o_addr),
    .i_instr        (i_instr),
    .i_stall        (i_stall),
    .i_branch_taken (i_branch_taken),
    .i_branch_target(i_branch_target),
    .i_jump         (i_jump),
    .i_jump_target  (i_jump_target),
    .i_debug_mode   (i_debug_mode),
    .i_step         (i_step),
    .o_ifid_instr   (o_ifid_instr),
    .o_ifid_pc4     (o_ifid_pc4),
    .o_ifid_valid   (o_ifid_valid),
    .o_pc           (o_pc),
    .o_halted       (o_halted),
    .o_fetch_count  (o_fetch_count)
  );

  always #5 clka = ~clka;

  // Low-latency RAM: word address ignores byte bits, sampled on negedge.
  always @(negedge clka) ram_dout <= mem[o_addr[10:2]];
  assign i_instr = ram_dout;

  function automatic logic [140:0] obs_vec();
    return {o_ifid_instr, (m_valid ? o_ifid_pc4 : 32'h0), o_ifid_valid,
            o_pc, o_addr, o_halted, o_fetch_count};
  endfunction

  function automatic logic [140:0] exp_vec();
    return {m_instr, (m_valid ? m_pc4 : 32'h0), m_valid,
            m_pc, m_pc[10:0], m_halted, m_count};
  endfunction

  task automatic fill_mem(input int halt_pct);
    logic [31:0] w;
    for (int i = 0; i < 512; i++) begin
      w = $urandom;
      if (w == HALT_INSTR) w = 32'h1234_5678;
      if ($urandom_range(99) < halt_pct) w = HALT_INSTR;
      mem[i] = w;
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = NOP_INSTR; m_pc4 = 32'h0;
    m_valid = 1'b0; m_halted = 1'b0; m_count = 32'h0;
  endtask

  task automatic model_step(input logic st, br, jp, stp,
                            input logic [31:0] bt, jt);
    logic [31:0] w;
    w = mem[m_pc[10:2]];
    if (m_halted) begin
      m_instr = NOP_INSTR; m_valid = 1'b0; m_pc4 = 32'h0;
    end else if (br || jp) begin
      m_pc = br ? bt : jt;
      m_instr = NOP_INSTR; m_valid = 1'b0; m_pc4 = 32'h0;
    end else if (st || (dbg && !stp)) begin
      // everything holds
    end else begin
      m_instr = w; m_pc4 = m_pc + 32'd4; m_valid = 1'b1; m_count = m_count + 32'd1;
      if (w == HALT_INSTR) m_halted = 1'b1;
      else m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic drive_idle();
    i_stall = 1'b0; i_branch_taken = 1'b0; i_branch_target = 32'h0;
    i_jump = 1'b0; i_jump_target = 32'h0; i_step = 1'b0;
    i_debug_mode = dbg;
  endtask

  task automatic do_reset();
    drive_idle();
    rst_n = 1'b0;
    model_reset();
    @(posedge clka);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic do_cycle(input logic st, br, jp, stp,
                          input logic [31:0] bt, jt);
    i_stall = st; i_branch_taken = br; i_branch_target = bt;
    i_jump = jp; i_jump_target = jt; i_step = stp; i_debug_mode = dbg;
    @(posedge clka);
    model_step(st, br, jp, stp, bt, jt);
    #1;
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    #3;
    checks++; if (o_ifid_instr !== NOP_INSTR) begin errors++; $display("[TB] FAIL reset_instr: got %h want %h", o_ifid_instr, NOP_INSTR); end
    checks++; if (o_ifid_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b want 0", o_ifid_valid); end
    checks++; if (o_ifid_pc4 !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc4: got %h want 0", o_ifid_pc4); end
    checks++; if (o_pc !== 32'h0 || o_addr !== 11'h0) begin errors++; $display("[TB] FAIL reset_pc: got pc %h addr %h want 0", o_pc, o_addr); end
    checks++; if (o_halted !== 1'b0 || o_fetch_count !== 32'h0) begin errors++; $display("[TB] FAIL reset_status: got halted %b count %0d want 0/0", o_halted, o_fetch_count); end
    do_reset();
    do_cycle(0, 0, 0, 0, 0, 0);
    checks++; if (o_ifid_valid !== 1'b1 || o_ifid_instr !== mem[0]) begin errors++; $display("[TB] FAIL reset_first_fetch: got %b/%h want 1/%h", o_ifid_valid, o_ifid_instr, mem[0]); end
  endtask

  task automatic test_sequential();
    fill_mem(0);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      do_cycle(0, 0, 0, 0, 0, 0);
      checks++;
      if (o_ifid_instr !== mem[i] || o_ifid_pc4 !== 32'(4 * (i + 1)) || o_ifid_valid !== 1'b1) begin
        errors++; $display("[TB] FAIL seq_word%0d: got %h/%h/%b want %h/%h/1", i, o_ifid_instr, o_ifid_pc4, o_ifid_valid, mem[i], 32'(4 * (i + 1)));
      end
    end
    checks++; if (o_fetch_count !== 32'd4) begin errors++; $display("[TB] FAIL seq_count: got %0d want 4", o_fetch_count); end
  endtask

  task automatic test_stall();
    fill_mem(0);
    do_reset();
    do_cycle(0, 0, 0, 0, 0, 0);
    do_cycle(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      do_cycle(1, 0, 0, 0, 0, 0);
      checks++;
      if (o_ifid_instr !== mem[1] || o_pc !== 32'h8 || o_fetch_count !== 32'd2) begin
        errors++; $display("[TB] FAIL stall_hold%0d: got %h pc %h cnt %0d want %h pc 8 cnt 2", i, o_ifid_instr, o_pc, o_fetch_count, mem[1]);
      end
    end
    do_cycle(0, 0, 0, 0, 0, 0);
    checks++; if (o_ifid_instr !== mem[2] || o_ifid_pc4 !== 32'd12) begin errors++; $display("[TB] FAIL stall_release: got %h/%h want %h/0000000c", o_ifid_instr, o_ifid_pc4, mem[2]); end
  endtask

  task automatic test_branch();
    fill_mem(0);
    do_reset();
    do_cycle(0, 0, 0, 0, 0, 0);
    do_cycle(0, 0, 0, 0, 0, 0);
    do_cycle(0, 1, 1, 0, 32'h40, 32'h80);
    checks++; if (o_ifid_valid !== 1'b0 || o_ifid_instr !== NOP_INSTR || o_pc !== 32'h40) begin errors++; $display("[TB] FAIL branch_flush: got %b/%h pc %h want 0/%h pc 40", o_ifid_valid, o_ifid_instr, o_pc, NOP_INSTR); end
    do_cycle(0, 0, 0, 0, 0, 0);
    checks++; if (o_ifid_valid !== 1'b1 || o_ifid_instr !== mem[16] || o_ifid_pc4 !== 32'h44) begin errors++; $display("[TB] FAIL branch_target_fetch: got %b/%h/%h want 1/%h/44", o_ifid_valid, o_ifid_instr, o_ifid_pc4, mem[16]); end
    do_cycle(1, 0, 1, 0, 0, 32'h80);
    checks++; if (o_pc !== 32'h80 || o_ifid_valid !== 1'b0) begin errors++; $display("[TB] FAIL jump_over_stall: got pc %h valid %b want 80/0", o_pc, o_ifid_valid); end
    do_cycle(0, 0, 0, 0, 0, 0);
    checks++; if (o_ifid_instr !== mem[32] || o_ifid_pc4 !== 32'h84) begin errors++; $display("[TB] FAIL jump_target_fetch: got %h/%h want %h/84", o_ifid_instr, o_ifid_pc4, mem[32]); end
  endtask

  task automatic test_halt();
    fill_mem(0);
    mem[2] = HALT_INSTR;
    do_reset();
    for (int i = 0; i < 3; i++) do_cycle(0, 0, 0, 0, 0, 0);
    checks++; if (o_ifid_instr !== HALT_INSTR || o_ifid_valid !== 1'b1 || o_ifid_pc4 !== 32'd12) begin errors++; $display("[TB] FAIL halt_word: got %h/%b/%h want ffffffff/1/c", o_ifid_instr, o_ifid_valid, o_ifid_pc4); end
    checks++; if (o_halted !== 1'b1 || o_pc !== 32'h8 || o_fetch_count !== 32'd3) begin errors++; $display("[TB] FAIL halt_state: got halted %b pc %h cnt %0d want 1/8/3", o_halted, o_pc, o_fetch_count); end
    do_cycle(0, 0, 0, 0, 0, 0);
    do_cycle(0, 1, 0, 0, 32'h40, 0);
    do_cycle(0, 0, 0, 0, 0, 0);
    checks++; if (o_ifid_valid !== 1'b0 || o_ifid_instr !== NOP_INSTR || o_pc !== 32'h8 || o_fetch_count !== 32'd3 || o_halted !== 1'b1) begin
      errors++; $display("[TB] FAIL halt_frozen: got %b/%h pc %h cnt %0d halted %b want 0/0 pc 8 cnt 3 halted 1", o_ifid_valid, o_ifid_instr, o_pc, o_fetch_count, o_halted);
    end
    do_reset();
    do_cycle(0, 0, 0, 0, 0, 0);
    do_cycle(0, 0, 0, 0, 0, 0);
    do_cycle(0, 1, 0, 0, 32'h40, 0);
    checks++; if (o_halted !== 1'b0 || o_pc !== 32'h40 || o_ifid_valid !== 1'b0) begin errors++; $display("[TB] FAIL halt_wrong_path: got halted %b pc %h valid %b want 0/40/0", o_halted, o_pc, o_ifid_valid); end
    do_cycle(0, 0, 0, 0, 0, 0);
    checks++; if (o_ifid_valid !== 1'b1 || o_ifid_instr !== mem[16]) begin errors++; $display("[TB] FAIL halt_wrong_path_resume: got %b/%h want 1/%h", o_ifid_valid, o_ifid_instr, mem[16]); end
  endtask

  task automatic test_debug();
    fill_mem(0);
    dbg = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      do_cycle(0, 0, 0, 0, 0, 0);
      checks++;
      if (o_fetch_count !== 32'd0 || o_ifid_valid !== 1'b0 || o_pc !== 32'h0) begin
        errors++; $display("[TB] FAIL debug_idle%0d: got cnt %0d valid %b pc %h want 0/0/0", i, o_fetch_count, o_ifid_valid, o_pc);
      end
    end
    for (int k = 0; k < 3; k++) begin
      do_cycle(0, 0, 0, 1, 0, 0);
      do_cycle(0, 0, 0, 0, 0, 0);
      do_cycle(0, 0, 0, 0, 0, 0);
    end
    checks++; if (o_fetch_count !== 32'd3 || o_pc !== 32'd12 || o_ifid_instr !== mem[2] || o_ifid_pc4 !== 32'd12) begin
      errors++; $display("[TB] FAIL debug_steps: got cnt %0d pc %h instr %h pc4 %h want 3/c/%h/c", o_fetch_count, o_pc, o_ifid_instr, o_ifid_pc4, mem[2]);
    end
    dbg = 1'b0;
  endtask

  task automatic test_wrap();
    fill_mem(0);
    do_reset();
    do_cycle(0, 0, 1, 0, 0, 32'hFFFF_FFFC);
    checks++; if (o_pc !== 32'hFFFF_FFFC || o_addr !== 11'h7FC) begin errors++; $display("[TB] FAIL wrap_target: got pc %h addr %h want fffffffc/7fc", o_pc, o_addr); end
    do_cycle(0, 0, 0, 0, 0, 0);
    checks++; if (o_ifid_instr !== mem[511] || o_ifid_pc4 !== 32'h0 || o_pc !== 32'h0) begin errors++; $display("[TB] FAIL wrap_fetch: got %h/%h pc %h want %h/0 pc 0", o_ifid_instr, o_ifid_pc4, o_pc, mem[511]); end
    do_cycle(0, 0, 0, 0, 0, 0);
    checks++; if (o_ifid_instr !== mem[0] || o_ifid_pc4 !== 32'h4) begin errors++; $display("[TB] FAIL wrap_next: got %h/%h want %h/4", o_ifid_instr, o_ifid_pc4, mem[0]); end
  endtask

  task automatic test_async_reset();
    fill_mem(0);
    do_reset();
    for (int i = 0; i < 5; i++) do_cycle(0, 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (o_pc !== 32'h0 || o_addr !== 11'h0 || o_ifid_valid !== 1'b0 || o_ifid_instr !== NOP_INSTR || o_ifid_pc4 !== 32'h0 || o_fetch_count !== 32'h0 || o_halted !== 1'b0) begin
      errors++; $display("[TB] FAIL async_reset: got pc %h addr %h valid %b instr %h pc4 %h cnt %0d halted %b want all zero", o_pc, o_addr, o_ifid_valid, o_ifid_instr, o_ifid_pc4, o_fetch_count, o_halted);
    end
    model_reset();
    rst_n = 1'b1;
    do_cycle(0, 0, 0, 0, 0, 0);
    checks++; if (o_ifid_instr !== mem[0] || o_ifid_pc4 !== 32'h4 || o_fetch_count !== 32'd1) begin errors++; $display("[TB] FAIL async_restart: got %h/%h cnt %0d want %h/4 cnt 1", o_ifid_instr, o_ifid_pc4, o_fetch_count, mem[0]); end
  endtask

  task automatic test_random();
    logic        st, br, jp, stp;
    logic [31:0] bt, jt;
    fill_mem(3);
    for (int seg = 0; seg < 6; seg++) begin
      dbg = ($urandom_range(2) == 0);
      do_reset();
      for (int c = 0; c < 60; c++) begin
        st  = ($urandom_range(99) < 20);
        br  = ($urandom_range(99) < 8);
        jp  = ($urandom_range(99) < 8);
        stp = ($urandom_range(1) == 1);
        bt  = ($urandom_range(9) == 0) ? $urandom : ($urandom & 32'h0000_07FC);
        jt  = ($urandom_range(9) == 0) ? $urandom : ($urandom & 32'h0000_07FC);
        do_cycle(st, br, jp, stp, bt, jt);
        checks++;
        if (obs_vec() !== exp_vec()) begin
          errors++; $display("[TB] FAIL random_seg%0d_cyc%0d: got %h want %h", seg, c, obs_vec(), exp_vec());
        end
      end
    end
    dbg = 1'b0;
  endtask

  initial begin
    fill_mem(0);
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_halt();
    test_debug();
    test_wrap();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
